// File: rtl/div_share_arbiter.sv
// -----------------------------------------------------------------------------
// div_share_arbiter
// Shares one external combinational Q8.8 divider among N_REQ requesters.
// A round-robin arbiter accepts one request at a time and registers its
// operands. The operands are held on the divider inputs for DIV_LAT cycles
// because the divider is a multicycle path. The quotient is then captured
// and returned to the winner over a valid/ready response handshake.
// A zero denominator never reaches the divider. A saturated result and a
// flag are returned in that case instead.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   req_valid  per-requester request
//   req_ready  per-requester accept (one-hot or zero, combinational in IDLE)
//   req_num    packed numerators, requester i at [i*DATA_W +: DATA_W]
//   req_den    packed denominators, same packing
//   rsp_valid  per-requester result valid (one-hot or zero)
//   rsp_ready  per-requester result accept
//   rsp_data   shared quotient bus
//   rsp_dz     divide-by-zero flag qualifying rsp_data
//   div_in1    divider numerator
//   div_in2    divider denominator (never zero)
//   div_out    divider quotient
//   busy       high whenever the FSM is not in IDLE
//
// state  | meaning
// IDLE   | scanning requests round-robin from rr_ptr; accept the first one found
// SETTLE | operands held on the divider; lat_cnt counts down to the sample edge
// RESP   | result presented to the granted requester until it accepts
// -----------------------------------------------------------------------------
module div_share_arbiter #(
   parameter int N_REQ   = 4,
   parameter int DATA_W  = 16,
   parameter int DIV_LAT = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [N_REQ-1:0]          req_valid,
   output logic [N_REQ-1:0]          req_ready,
   input  logic [N_REQ*DATA_W-1:0]   req_num,
   input  logic [N_REQ*DATA_W-1:0]   req_den,
   output logic [N_REQ-1:0]          rsp_valid,
   input  logic [N_REQ-1:0]          rsp_ready,
   output logic [DATA_W-1:0]         rsp_data,
   output logic                      rsp_dz,
   output logic [DATA_W-1:0]         div_in1,
   output logic [DATA_W-1:0]         div_in2,
   input  logic [DATA_W-1:0]         div_out,
   output logic                      busy
);

   localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int LAT_W = 4;
   localparam logic [DATA_W-1:0] SAT_POS = {1'b0, {(DATA_W-1){1'b1}}};
   localparam logic [DATA_W-1:0] SAT_NEG = {1'b1, {(DATA_W-1){1'b0}}};
   localparam logic [DATA_W-1:0] ONE     = DATA_W'(1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETTLE = 2'd1,
      S_RESP   = 2'd2
   } state_t;

   state_t              state_q,    state_d;
   logic [IDX_W-1:0]    rr_ptr_q,   rr_ptr_d;
   logic [IDX_W-1:0]    grant_q,    grant_d;
   logic [LAT_W-1:0]    lat_cnt_q,  lat_cnt_d;
   logic [DATA_W-1:0]   op_num_q,   op_num_d;
   logic [DATA_W-1:0]   op_den_q,   op_den_d;
   logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
   logic                rsp_dz_q,   rsp_dz_d;

   logic                win_found;
   logic [IDX_W-1:0]    win_idx;
   logic                den_zero;

   // Round-robin scan: first asserted request at or after rr_ptr, wrapping.
   always_comb begin
      int               idx;
      logic [IDX_W-1:0] cand;
      idx       = 0;
      cand      = '0;
      win_found = 1'b0;
      win_idx   = '0;
      for (int k = 0; k < N_REQ; k++) begin
         idx = int'(rr_ptr_q) + k;
         if (idx >= N_REQ) begin
            idx = idx - N_REQ;
         end
         cand = IDX_W'(idx);
         if (!win_found && req_valid[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

   assign den_zero = (op_den_q == '0);

   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      grant_d    = grant_q;
      lat_cnt_d  = lat_cnt_q;
      op_num_d   = op_num_q;
      op_den_d   = op_den_q;
      rsp_data_d = rsp_data_q;
      rsp_dz_d   = rsp_dz_q;
      req_ready  = '0;
      rsp_valid  = '0;

      case (state_q)
         S_IDLE: begin
            if (win_found) begin
               // Gated by rst so the accept strobe drops as soon as reset asserts.
               req_ready[win_idx] = ~rst;
               op_num_d           = req_num[win_idx*DATA_W +: DATA_W];
               op_den_d           = req_den[win_idx*DATA_W +: DATA_W];
               grant_d            = win_idx;
               lat_cnt_d          = LAT_W'(DIV_LAT);
               state_d            = S_SETTLE;
            end
         end
         S_SETTLE: begin
            lat_cnt_d = lat_cnt_q - 1'b1;
            if (lat_cnt_q == LAT_W'(1)) begin
               if (den_zero) begin
                  rsp_data_d = op_num_q[DATA_W-1] ? SAT_NEG : SAT_POS;
                  rsp_dz_d   = 1'b1;
               end else begin
                  rsp_data_d = div_out;
                  rsp_dz_d   = 1'b0;
               end
               state_d = S_RESP;
            end
         end
         S_RESP: begin
            rsp_valid[grant_q] = 1'b1;
            if (rsp_ready[grant_q]) begin
               rr_ptr_d = (grant_q == IDX_W'(N_REQ-1)) ? '0 : grant_q + 1'b1;
               state_d  = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         rr_ptr_q   <= '0;
         grant_q    <= '0;
         lat_cnt_q  <= '0;
         op_num_q   <= '0;
         op_den_q   <= '0;
         rsp_data_q <= '0;
         rsp_dz_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         grant_q    <= grant_d;
         lat_cnt_q  <= lat_cnt_d;
         op_num_q   <= op_num_d;
         op_den_q   <= op_den_d;
         rsp_data_q <= rsp_data_d;
         rsp_dz_q   <= rsp_dz_d;
      end
   end

   // The divider is driven straight from the operand registers. After reset
   // these registers are zero, which presents 0 / 1 to the divider.
   assign div_in1  = op_num_q;
   assign div_in2  = den_zero ? ONE : op_den_q;
   assign rsp_data = rsp_data_q;
   assign rsp_dz   = rsp_dz_q;
   assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_div_share_arbiter.sv
module tb_div_share_arbiter;

   localparam int N   = 4;
   localparam int W   = 16;
   localparam int LAT = 2;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    req_valid;
   logic [N-1:0]    req_ready;
   logic [N*W-1:0]  req_num;
   logic [N*W-1:0]  req_den;
   logic [N-1:0]    rsp_valid;
   logic [N-1:0]    rsp_ready;
   logic [W-1:0]    rsp_data;
   logic            rsp_dz;
   logic [W-1:0]    div_in1;
   logic [W-1:0]    div_in2;
   logic [W-1:0]    div_out;
   logic            busy;

   div_share_arbiter #(.N_REQ(N), .DATA_W(W), .DIV_LAT(LAT)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_num(req_num), .req_den(req_den),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_data(rsp_data), .rsp_dz(rsp_dz),
      .div_in1(div_in1), .div_in2(div_in2), .div_out(div_out),
      .busy(busy)
   );

   always #5 clk = ~clk;

   // (a <<< 8) / b in signed arithmetic, low 16 bits kept.
   function automatic logic [15:0] qdiv(input logic [15:0] a, input logic [15:0] b);
      int n, d, q;
      n = int'($signed(a)) * 256;
      d = int'($signed(b));
      if (d == 0) return 16'hDEAD;
      q = n / d;
      return q[15:0];
   endfunction

   // Reference result: {dz, data}
   function automatic logic [16:0] ref_op(input logic [15:0] num, input logic [15:0] den);
      if (den == 16'h0000) return {1'b1, (num[15] ? 16'h8000 : 16'h7FFF)};
      return {1'b0, qdiv(num, den)};
   endfunction

   assign div_out = qdiv(div_in1, div_in2);

   typedef struct {
      int          g;
      logic [15:0] d;
      logic        dz;
   } exp_t;

   exp_t        exp_q[$];
   int          log_g[$];
   int          log_c[$];
   int          cyc = 0;
   int          n_checks = 0;
   int          n_errors = 0;
   logic [15:0] last_data;
   logic        last_dz;
   int          rr_mode = 0;
   logic [N-1:0] rr_fixed = '1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: actual=%h required=%h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic fail_timeout(input string nm);
      n_checks++;
      n_errors++;
      $display("FAIL %s: actual=timeout required=event (t=%0t)", nm, $time);
   endtask

   // Behavioural model: one operation at a time, round-robin from a pointer,
   // result visible DIV_LAT+1 cycles after the accept cycle.
   bit          m_idle = 1'b1;
   int          m_ptr = 0;
   int          m_grant = 0;
   int          m_cnt = 0;
   logic [15:0] m_den = '0;

   initial begin
      forever begin : mdl
         int          j, w;
         bit          found;
         logic [N-1:0] exp_rdy;
         logic [15:0] num, den;
         logic [16:0] r;
         exp_t        e;
         @(negedge clk);
         cyc++;
         if (rst) begin
            m_idle = 1'b1;
            m_ptr  = 0;
            m_cnt  = 0;
            exp_q.delete();
         end else begin
            for (int k = 0; k < N; k++) begin
               if (req_ready[k]) begin
                  log_g.push_back(k);
                  log_c.push_back(cyc);
               end
            end
            if (m_idle) begin
               found = 1'b0;
               w     = 0;
               for (int k = 0; k < N; k++) begin
                  j = (m_ptr + k) % N;
                  if (!found && req_valid[j]) begin
                     found = 1'b1;
                     w     = j;
                  end
               end
               exp_rdy = found ? (N'(1) << w) : '0;
               chk("req_ready_idle", req_ready, exp_rdy);
               chk("busy_idle", busy, 0);
               chk("rsp_valid_idle", rsp_valid, 0);
               if (found) begin
                  num  = req_num[w*W +: W];
                  den  = req_den[w*W +: W];
                  r    = ref_op(num, den);
                  e.g  = w;
                  e.d  = r[15:0];
                  e.dz = r[16];
                  exp_q.push_back(e);
                  m_idle  = 1'b0;
                  m_cnt   = LAT;
                  m_grant = w;
                  m_den   = den;
               end
            end else if (m_cnt > 0) begin
               chk("req_ready_settle", req_ready, 0);
               chk("busy_settle", busy, 1);
               chk("rsp_valid_settle", rsp_valid, 0);
               chk("div_in2_settle", div_in2, (m_den == 16'h0) ? 16'h0001 : m_den);
               m_cnt--;
            end else begin
               chk("rsp_valid_resp", rsp_valid, N'(1) << m_grant);
               chk("req_ready_resp", req_ready, 0);
               chk("busy_resp", busy, 1);
               if (rsp_ready[m_grant]) begin
                  m_ptr  = (m_grant + 1) % N;
                  m_idle = 1'b1;
               end
            end
         end
      end
   end

   // Response monitor: compares presented results against the scoreboard.
   initial begin
      forever begin : mon
         exp_t e;
         @(negedge clk);
         if (!rst && rsp_valid != '0) begin
            if (exp_q.size() == 0) begin
               chk("rsp_unexpected", rsp_valid, 0);
            end else begin
               e = exp_q[0];
               chk("rsp_valid_onehot", rsp_valid, N'(1) << e.g);
               chk("rsp_data", rsp_data, e.d);
               chk("rsp_dz", rsp_dz, e.dz);
               if ((rsp_valid & rsp_ready) != '0) begin
                  last_data = rsp_data;
                  last_dz   = rsp_dz;
                  void'(exp_q.pop_front());
               end
            end
         end
      end
   end

   // Response-side ready driver.
   initial begin
      rsp_ready = '1;
      forever begin
         @(posedge clk);
         #1;
         case (rr_mode)
            0:       rsp_ready = '1;
            1:       rsp_ready = N'($urandom);
            default: rsp_ready = rr_fixed;
         endcase
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_log(input int n, input string nm);
      bit ok;
      ok = 1'b0;
      for (int t = 0; t < 200 && !ok; t++) begin
         @(negedge clk);
         #1;
         if (log_g.size() >= n) ok = 1'b1;
      end
      if (!ok) fail_timeout(nm);
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle(input string nm);
      bit ok;
      ok = 1'b0;
      for (int t = 0; t < 2000 && !ok; t++) begin
         @(negedge clk);
         #1;
         if (!busy && exp_q.size() == 0) ok = 1'b1;
      end
      if (!ok) fail_timeout(nm);
      @(posedge clk);
      #1;
   endtask

   task automatic set_op(input int k, input logic [15:0] num, input logic [15:0] den);
      req_num[k*W +: W] = num;
      req_den[k*W +: W] = den;
   endtask

   task automatic do_op(input int k, input logic [15:0] num, input logic [15:0] den,
                        input logic [15:0] exp_d, input logic exp_dz, input string nm);
      log_g.delete();
      log_c.delete();
      last_data = 16'h5A5A;
      last_dz   = 1'bx;
      set_op(k, num, den);
      req_valid[k] = 1'b1;
      wait_log(1, {nm, "_accept"});
      req_valid[k] = 1'b0;
      if (log_g.size() > 0) chk({nm, "_grant"}, log_g[0], k);
      wait_idle({nm, "_idle"});
      chk({nm, "_data"}, last_data, exp_d);
      chk({nm, "_dz"}, last_dz, exp_dz);
   endtask

   task automatic drive_rand(input int k);
      logic [15:0] num, den;
      bit acc, wd;
      int gap;
      for (int n = 0; n < 8; n++) begin
         gap = $urandom_range(0, 4);
         repeat (gap) begin
            @(posedge clk);
            #1;
         end
         num = 16'($urandom);
         den = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
         set_op(k, num, den);
         req_valid[k] = 1'b1;
         acc = 1'b0;
         wd  = 1'b0;
         for (int t = 0; t < 400 && !acc && !wd; t++) begin
            @(negedge clk);
            #1;
            if (req_ready[k]) acc = 1'b1;
            else if ($urandom_range(0, 30) == 0) wd = 1'b1;
         end
         @(posedge clk);
         #1;
         if (!acc && !wd) fail_timeout("rand_accept");
         if (wd || $urandom_range(0, 1) == 0) req_valid[k] = 1'b0;
      end
      req_valid[k] = 1'b0;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: actual=running required=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [15:0] held;
      bit          seen;
      rst       = 1'b1;
      req_valid = '0;
      req_num   = '0;
      req_den   = '0;
      tick(2);

      // Reset values, with every request line raised during reset.
      req_valid = '1;
      #1;
      chk("rst_req_ready", req_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_data", rsp_data, 0);
      chk("rst_rsp_dz", rsp_dz, 0);
      chk("rst_busy", busy, 0);
      chk("rst_div_in1", div_in1, 0);
      chk("rst_div_in2", div_in2, 16'h0001);
      req_valid = '0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      tick(2);

      // Fairness: all four held high, rsp_ready tied high.
      log_g.delete();
      log_c.delete();
      for (int k = 0; k < N; k++) set_op(k, 16'((k + 1) * 256), 16'h0200);
      req_valid = '1;
      wait_log(6, "fair_accept");
      req_valid = '0;
      wait_idle("fair_idle");
      for (int k = 0; k < 6 && k < log_g.size(); k++) begin
         chk("fair_grant", log_g[k], k % N);
         if (k > 0) chk("fair_spacing", log_c[k] - log_c[k-1], LAT + 2);
      end

      // Backpressure on requester 2 with requesters 3 and 0 pending.
      rr_fixed = 4'b1011;
      rr_mode  = 2;
      tick(1);
      log_g.delete();
      log_c.delete();
      set_op(0, 16'h0100, 16'h0100);
      set_op(2, 16'h0500, 16'h0200);
      set_op(3, 16'hF800, 16'h0400);
      req_valid = 4'b1101;
      wait_log(1, "bp_accept2");
      req_valid[2] = 1'b0;
      if (log_g.size() > 0) chk("bp_grant_first", log_g[0], 2);
      seen = 1'b0;
      for (int t = 0; t < 20 && !seen; t++) begin
         @(negedge clk);
         #1;
         if (rsp_valid[2]) seen = 1'b1;
      end
      if (!seen) fail_timeout("bp_rsp_valid");
      held = rsp_data;
      for (int t = 0; t < 5; t++) begin
         chk("bp_rsp_valid_held", rsp_valid, 4'b0100);
         chk("bp_rsp_data_held", rsp_data, held);
         chk("bp_busy", busy, 1);
         chk("bp_no_ready", req_ready, 0);
         @(negedge clk);
         #1;
      end
      rr_mode = 0;
      wait_log(2, "bp_accept3");
      req_valid[3] = 1'b0;
      if (log_g.size() > 1) chk("bp_grant_next", log_g[1], 3);
      wait_log(3, "bp_accept0");
      req_valid[0] = 1'b0;
      if (log_g.size() > 2) chk("bp_grant_last", log_g[2], 0);
      wait_idle("bp_idle");

      // Directed arithmetic.
      do_op(1, 16'h0100, 16'h0200, 16'h0080, 1'b0, "single_r1");
      do_op(0, 16'hFF00, 16'h0200, 16'hFF80, 1'b0, "signed_a");
      do_op(0, 16'h0300, 16'hFE00, 16'hFE80, 1'b0, "signed_b");
      do_op(0, 16'h0300, 16'h0000, 16'h7FFF, 1'b1, "dz_pos");
      do_op(0, 16'hFD00, 16'h0000, 16'h8000, 1'b1, "dz_neg");
      do_op(2, 16'h7F00, 16'h0010, qdiv(16'h7F00, 16'h0010), 1'b0, "wrap");

      // Reset during SETTLE.
      log_g.delete();
      log_c.delete();
      set_op(1, 16'h0100, 16'h0100);
      req_valid[1] = 1'b1;
      wait_log(1, "rst_mid_accept");
      req_valid[1] = 1'b0;
      chk("rst_mid_pre_busy", busy, 1);
      rst = 1'b1;
      #1;
      chk("rst_mid_busy", busy, 0);
      chk("rst_mid_rsp_valid", rsp_valid, 0);
      chk("rst_mid_rsp_data", rsp_data, 0);
      chk("rst_mid_rsp_dz", rsp_dz, 0);
      chk("rst_mid_div_in1", div_in1, 0);
      chk("rst_mid_div_in2", div_in2, 16'h0001);
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int t = 0; t < 5; t++) begin
         @(negedge clk);
         #1;
         chk("rst_mid_no_rsp", rsp_valid, 0);
      end
      @(posedge clk);
      #1;
      log_g.delete();
      log_c.delete();
      set_op(0, 16'h0200, 16'h0100);
      set_op(3, 16'h0100, 16'h0300);
      req_valid = 4'b1001;
      wait_log(1, "post_rst_accept0");
      req_valid[0] = 1'b0;
      if (log_g.size() > 0) chk("post_rst_grant", log_g[0], 0);
      wait_log(2, "post_rst_accept3");
      req_valid[3] = 1'b0;
      wait_idle("post_rst_idle");

      // Randomized traffic with random response backpressure.
      rr_mode = 1;
      for (int i = 0; i < N; i++) begin
         fork
            automatic int k = i;
            drive_rand(k);
         join_none
      end
      wait fork;
      rr_mode = 0;
      wait_idle("rand_idle");
      chk("scoreboard_empty", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/div_share_arbiter.md
Name: div_share_arbiter

Overview:
- Shares the single 16-bit signed Q8.8 combinational divider among N_REQ requesters. The divider computes (in1 <<< 8) / in2 and returns the low 16 bits.
- Arbitrates round-robin and registers the winning operands.
- Holds the divider inputs stable for a programmable settle time (multicycle path), then captures the quotient and returns it to the granted requester over a valid/ready response handshake.
- Intercepts divide-by-zero so the divider never sees a zero denominator.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- DATA_W, 16, operand/result width; fixed to the divider width.
- DIV_LAT, 2, cycles divider inputs are held before the result is sampled (1..15).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  N_REQ  per-requester operation request.
- req_ready  out  N_REQ  per-requester accept; one-hot or zero.
- req_num  in  N_REQ*DATA_W  packed Q8.8 numerators; requester i at [i*16 +: 16].
- req_den  in  N_REQ*DATA_W  packed Q8.8 denominators.
- rsp_valid  out  N_REQ  per-requester result valid; one-hot or zero.
- rsp_ready  in  N_REQ  per-requester result accept.
- rsp_data  out  DATA_W  quotient, shared bus; meaningful only for the requester with rsp_valid set.
- rsp_dz  out  1  divide-by-zero flag qualifying rsp_data.
- div_in1  out  DATA_W  to divider numerator.
- div_in2  out  DATA_W  to divider denominator.
- div_out  in  DATA_W  from divider quotient.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async assert, sync-released logic) sets:
  - state=IDLE; rr_ptr=0; grant=0; lat_cnt=0.
  - div_in1=0, div_in2=16'h0001.
  - req_ready=0, rsp_valid=0, rsp_data=0, rsp_dz=0, busy=0.
- FSM states are IDLE, SETTLE, RESP.
- IDLE:
  - Winner g is the first asserted req_valid scanning from rr_ptr upward, with wrap-around.
  - req_ready[g] is asserted combinationally the same cycle; no other ready bit is set.
  - On that edge: latch num/den of g into op regs, grant<=g, lat_cnt<=DIV_LAT, go to SETTLE.
  - If no req_valid is set, stay in IDLE.
- SETTLE:
  - div_in1=op_num.
  - div_in2 is op_den, or 16'h0001 when op_den==0 (zero is never presented to the divider).
  - lat_cnt decrements each cycle. On the edge where lat_cnt==1:
    - If op_den!=0: capture rsp_data<=div_out, rsp_dz<=0.
    - If op_den==0: rsp_data<=16'h7FFF when op_num[15]==0, else 16'h8000; rsp_dz<=1.
    - Go to RESP.
- RESP:
  - rsp_valid[grant]=1, held with rsp_data/rsp_dz stable until rsp_ready[grant]=1.
  - On that handshake edge: rr_ptr<=(grant+1) mod N_REQ, go to IDLE.
  - rsp_ready bits of non-granted requesters are ignored.
- Timing:
  - Latency from accept edge to first rsp_valid cycle is DIV_LAT+1 cycles.
  - Minimum issue interval is DIV_LAT+2 cycles; no new request is accepted outside IDLE.
- Arithmetic: quotient overflow wraps exactly as the divider truncates (low 16 bits); the block applies no saturation except for divide-by-zero.
- Boundaries:
  - req_valid dropping before accept is legal; no grant is made.
  - req_valid held high after accept is treated as a new request on the next IDLE visit.
  - rsp_ready asserted in the same cycle rsp_valid first rises completes the handshake in one cycle.
  - If rr_ptr points at a non-requesting index, the scan continues with wrap-around.
- Reset asserted in any state aborts the operation: outputs go to reset values immediately and the in-flight result is discarded.

Test Plan:
- Single op, requester 1: num=16'h0100, den=16'h0200, DIV_LAT=2 -> req_ready[1] on accept cycle; rsp_valid[1] 3 cycles later; rsp_data=16'h0080, rsp_dz=0.
- Signed op, requester 0: num=16'hFF00 (-1.0), den=16'h0200 -> rsp_data=16'hFF80; num=16'h0300, den=16'hFE00 -> rsp_data=16'hFE80.
- Divide by zero: num=16'h0300, den=0 -> div_in2 observed as 16'h0001 throughout SETTLE; rsp_data=16'h7FFF, rsp_dz=1. num=16'hFD00, den=0 -> rsp_data=16'h8000, rsp_dz=1.
- Fairness: all 4 req_valid held high continuously -> grant order 0,1,2,3,0,1; each accept spaced exactly DIV_LAT+2 cycles apart with rsp_ready tied high.
- Backpressure: rsp_ready[2] held low 5 cycles -> rsp_valid[2] and rsp_data held constant; busy=1; no req_ready to other pending requesters until the handshake, then the next grant is requester 3.
- Reset mid-SETTLE: assert rst for 1 cycle during SETTLE -> all outputs take reset values asynchronously; no rsp_valid follows. The next request from requester 0 is granted first.
